// File: rtl/lbp_pkg.sv
// Shared types for the LBP frame engine: FSM states, neighbour bit positions, border-mode encoding.
// Pure declarations, no timing or flow control of its own.
package lbp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CAL,
        WR,
        BORDER,
        DONE
    } state_e;

    typedef enum logic {
        BMODE_INTERIOR  = 1'b0,
        BMODE_ZERO_FILL = 1'b1
    } bmode_e;

    localparam int NB_TL = 0;
    localparam int NB_T  = 1;
    localparam int NB_TR = 2;
    localparam int NB_L  = 3;
    localparam int NB_R  = 4;
    localparam int NB_BL = 5;
    localparam int NB_B  = 6;
    localparam int NB_BR = 7;

    localparam logic [3:0] FULL_READS = 4'd9;
    localparam logic [3:0] COL_READS  = 4'd3;

    // Column-major walk of a 3x3 window: returns {col[1:0], row[1:0]} for read k.
    function automatic logic [3:0] full_tap(input logic [3:0] k);
        logic [3:0] t;
        case (k)
            4'd0:    t = {2'd0, 2'd0};
            4'd1:    t = {2'd0, 2'd1};
            4'd2:    t = {2'd0, 2'd2};
            4'd3:    t = {2'd1, 2'd0};
            4'd4:    t = {2'd1, 2'd1};
            4'd5:    t = {2'd1, 2'd2};
            4'd6:    t = {2'd2, 2'd0};
            4'd7:    t = {2'd2, 2'd1};
            4'd8:    t = {2'd2, 2'd2};
            default: t = 4'd0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/lbp_frame_engine_if.sv
// Bundle of the gray-memory read port, LBP-memory write port and per-frame controls.
// No storage; the engine owns all timing, the memories never stall it.
interface lbp_frame_engine_if #(
    parameter int PIX_W = 8,
    parameter int AW    = 14
);
    logic             gray_ready;
    logic [PIX_W-1:0] gray_data;
    logic [PIX_W-1:0] thr;
    logic             border_mode;
    logic [AW-1:0]    gray_addr;
    logic             gray_req;
    logic [AW-1:0]    lbp_addr;
    logic [7:0]       lbp_data;
    logic             lbp_valid;
    logic             finish;

    modport master (
        input  gray_ready, gray_data, thr, border_mode,
        output gray_addr, gray_req, lbp_addr, lbp_data, lbp_valid, finish
    );

    modport slave (
        output gray_ready, gray_data, thr, border_mode,
        input  gray_addr, gray_req, lbp_addr, lbp_data, lbp_valid, finish
    );
endinterface

// File: rtl/lbp_code.sv
// Combinational 3x3 LBP encoder: bit set when neighbour >= centre + thr (no wrap).
// Zero latency, no flow control.
module lbp_code #(
    parameter int PIX_W = 8
) (
    input  logic [PIX_W-1:0] p_tl,
    input  logic [PIX_W-1:0] p_t,
    input  logic [PIX_W-1:0] p_tr,
    input  logic [PIX_W-1:0] p_l,
    input  logic [PIX_W-1:0] p_c,
    input  logic [PIX_W-1:0] p_r,
    input  logic [PIX_W-1:0] p_bl,
    input  logic [PIX_W-1:0] p_b,
    input  logic [PIX_W-1:0] p_br,
    input  logic [PIX_W-1:0] thr,
    output logic [7:0]       code
);
    import lbp_pkg::*;

    // One extra bit so centre + thr saturates naturally above any pixel value.
    logic [PIX_W:0] ref_v;
    assign ref_v = {1'b0, p_c} + {1'b0, thr};

    always_comb begin
        code        = '0;
        code[NB_TL] = ({1'b0, p_tl} >= ref_v);
        code[NB_T]  = ({1'b0, p_t}  >= ref_v);
        code[NB_TR] = ({1'b0, p_tr} >= ref_v);
        code[NB_L]  = ({1'b0, p_l}  >= ref_v);
        code[NB_R]  = ({1'b0, p_r}  >= ref_v);
        code[NB_BL] = ({1'b0, p_bl} >= ref_v);
        code[NB_B]  = ({1'b0, p_b}  >= ref_v);
        code[NB_BR] = ({1'b0, p_br} >= ref_v);
    end
endmodule

// File: rtl/lbp_frame_engine.sv
// Frame-level LBP engine: fetches 3x3 windows, writes one code per interior pixel, optional zero border.
// 12 cycles per row-start pixel, 6 per following pixel; memories are assumed never to stall.
module lbp_frame_engine
    import lbp_pkg::*;
#(
    parameter int IMG_W = 128,
    parameter int IMG_H = 128,
    parameter int PIX_W = 8,
    parameter int AW    = $clog2(IMG_W * IMG_H)
) (
    input  logic               clk,
    input  logic               reset,
    lbp_frame_engine_if.master bus
);
    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);

    localparam logic [RW-1:0] ROW_LAST_IN = RW'(IMG_H - 2);
    localparam logic [RW-1:0] ROW_LAST    = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_LAST_IN = CW'(IMG_W - 2);
    localparam logic [CW-1:0] COL_LAST    = CW'(IMG_W - 1);
    localparam logic [CW-1:0] COL_ONE     = CW'(1);
    localparam logic [RW-1:0] ROW_ONE     = RW'(1);

    function automatic logic [AW-1:0] addr_of(input logic [RW-1:0] row, input logic [CW-1:0] col);
        return AW'(int'(row) * IMG_W + int'(col));
    endfunction

    function automatic logic [3:0] n_reads(input logic [CW-1:0] col);
        return (col == COL_ONE) ? FULL_READS : COL_READS;
    endfunction

    function automatic logic [AW-1:0] read_addr(input logic [RW-1:0] row, input logic [CW-1:0] col,
                                                input logic [3:0] k);
        logic [3:0]    tap;
        logic [RW-1:0] rr;
        logic [CW-1:0] cc;
        tap = full_tap(k);
        if (col == COL_ONE) begin
            cc = col - COL_ONE + CW'(tap[3:2]);
            rr = row - ROW_ONE + RW'(tap[1:0]);
        end else begin
            cc = col + COL_ONE;
            rr = row - ROW_ONE + RW'(k[1:0]);
        end
        return addr_of(rr, cc);
    endfunction

    state_e           state_q, state_d;
    logic [RW-1:0]    r_q, r_d;
    logic [CW-1:0]    c_q, c_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [PIX_W-1:0] thr_q, thr_d;
    bmode_e           bmode_q, bmode_d;
    logic [AW-1:0]    gray_addr_q, gray_addr_d;
    logic             gray_req_q, gray_req_d;
    logic [AW-1:0]    lbp_addr_q, lbp_addr_d;
    logic [7:0]       lbp_data_q, lbp_data_d;
    logic             lbp_valid_q, lbp_valid_d;
    logic             finish_q, finish_d;
    // Window indexed [col][row]; col 0 is the leftmost column.
    logic [PIX_W-1:0] win_q [3][3];
    logic [PIX_W-1:0] win_d [3][3];
    logic [7:0]       code;
    logic [3:0]       tap;

    lbp_code #(.PIX_W(PIX_W)) u_code (
        .p_tl (win_q[0][0]), .p_t (win_q[1][0]), .p_tr (win_q[2][0]),
        .p_l  (win_q[0][1]), .p_c (win_q[1][1]), .p_r  (win_q[2][1]),
        .p_bl (win_q[0][2]), .p_b (win_q[1][2]), .p_br (win_q[2][2]),
        .thr  (thr_q),
        .code (code)
    );

    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        c_d         = c_q;
        cnt_d       = cnt_q;
        thr_d       = thr_q;
        bmode_d     = bmode_q;
        win_d       = win_q;
        gray_req_d  = 1'b0;
        gray_addr_d = '0;
        lbp_valid_d = 1'b0;
        lbp_addr_d  = lbp_addr_q;
        lbp_data_d  = lbp_data_q;
        finish_d    = 1'b0;
        tap         = full_tap(cnt_q - 4'd1);

        case (state_q)
            IDLE: begin
                if (bus.gray_ready) begin
                    state_d = FETCH;
                    thr_d   = bus.thr;
                    bmode_d = bmode_e'(bus.border_mode);
                    r_d     = ROW_ONE;
                    c_d     = COL_ONE;
                    cnt_d   = 4'd0;
                end
            end
            FETCH: begin
                // Data for read cnt_q-1 is on gray_data during cycle cnt_q.
                if (cnt_q != 4'd0) begin
                    if (c_q == COL_ONE) win_d[tap[3:2]][tap[1:0]] = bus.gray_data;
                    else                win_d[2][cnt_q[1:0] - 2'd1] = bus.gray_data;
                end
                if (cnt_q == n_reads(c_q)) state_d = CAL;
                else                       cnt_d   = cnt_q + 4'd1;
            end
            CAL: begin
                state_d     = WR;
                lbp_valid_d = 1'b1;
                lbp_addr_d  = addr_of(r_q, c_q);
                lbp_data_d  = code;
            end
            WR: begin
                if (r_q == ROW_LAST_IN && c_q == COL_LAST_IN) begin
                    if (bmode_q == BMODE_ZERO_FILL) begin
                        state_d     = BORDER;
                        r_d         = '0;
                        c_d         = '0;
                        lbp_valid_d = 1'b1;
                        lbp_addr_d  = '0;
                        lbp_data_d  = 8'h00;
                    end else begin
                        state_d  = DONE;
                        finish_d = 1'b1;
                    end
                end else begin
                    state_d = FETCH;
                    cnt_d   = 4'd0;
                    if (c_q < COL_LAST_IN) begin
                        c_d      = c_q + COL_ONE;
                        win_d[0] = win_q[1];
                        win_d[1] = win_q[2];
                    end else begin
                        c_d = COL_ONE;
                        r_d = r_q + ROW_ONE;
                    end
                end
            end
            BORDER: begin
                // r_q/c_q hold the border address currently on lbp_addr.
                if (r_q == ROW_LAST && c_q == COL_LAST) begin
                    state_d  = DONE;
                    finish_d = 1'b1;
                end else begin
                    if (r_q == '0 || r_q == ROW_LAST) begin
                        if (c_q == COL_LAST) begin
                            r_d = r_q + ROW_ONE;
                            c_d = '0;
                        end else begin
                            c_d = c_q + COL_ONE;
                        end
                    end else if (c_q == '0) begin
                        c_d = COL_LAST;
                    end else begin
                        r_d = r_q + ROW_ONE;
                        c_d = '0;
                    end
                    lbp_valid_d = 1'b1;
                    lbp_addr_d  = addr_of(r_d, c_d);
                    lbp_data_d  = 8'h00;
                end
            end
            DONE: begin
                finish_d = 1'b1;
                if (!bus.gray_ready) begin
                    state_d  = IDLE;
                    finish_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d == FETCH && cnt_d < n_reads(c_d)) begin
            gray_req_d  = 1'b1;
            gray_addr_d = read_addr(r_d, c_d, cnt_d);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            r_q         <= '0;
            c_q         <= '0;
            cnt_q       <= '0;
            thr_q       <= '0;
            bmode_q     <= BMODE_INTERIOR;
            gray_addr_q <= '0;
            gray_req_q  <= 1'b0;
            lbp_addr_q  <= '0;
            lbp_data_q  <= '0;
            lbp_valid_q <= 1'b0;
            finish_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            c_q         <= c_d;
            cnt_q       <= cnt_d;
            thr_q       <= thr_d;
            bmode_q     <= bmode_d;
            gray_addr_q <= gray_addr_d;
            gray_req_q  <= gray_req_d;
            lbp_addr_q  <= lbp_addr_d;
            lbp_data_q  <= lbp_data_d;
            lbp_valid_q <= lbp_valid_d;
            finish_q    <= finish_d;
        end
    end

    always_ff @(posedge clk) begin
        win_q <= win_d;
    end

    assign bus.gray_addr = gray_addr_q;
    assign bus.gray_req  = gray_req_q;
    assign bus.lbp_addr  = lbp_addr_q;
    assign bus.lbp_data  = lbp_data_q;
    assign bus.lbp_valid = lbp_valid_q;
    assign bus.finish    = finish_q;
endmodule

// File: doc/lbp_frame_engine.md
# lbp_frame_engine

Parametrised local-binary-pattern engine for the image-processing path. It fetches an IMG_W x IMG_H grayscale frame through the gray-memory request port and computes an 8-bit LBP code for every interior pixel, comparing each neighbour against the centre plus a programmable threshold. It writes the codes through the lbp-memory write port and, when enabled, zero-fills the border addresses. It sits between the gray frame store and the LBP result store, and generalises the fixed 128x128 engine.

## Interface
- IMG_W, 128, frame width in pixels (>=3)
- IMG_H, 128, frame height in pixels (>=3)
- PIX_W, 8, gray pixel width
- AW, $clog2(IMG_W*IMG_H), address width (14 at defaults)
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- gray_ready  in  1  frame available; sampled in IDLE and DONE
- gray_data  in  PIX_W  pixel at the address requested on the previous cycle
- thr  in  PIX_W  comparison offset; sampled on frame start
- border_mode  in  1  0 = interior only, 1 = also write 0 to border addresses; sampled on frame start
- gray_addr  out  AW  read address, registered
- gray_req  out  1  read strobe, registered
- lbp_addr  out  AW  write address, registered
- lbp_data  out  8  LBP code, registered
- lbp_valid  out  1  write strobe, one cycle per write
- finish  out  1  frame complete, level

## Operation
- States: IDLE, FETCH, CAL, WR, BORDER, DONE.
- IDLE -> FETCH when gray_ready=1. Latch thr and border_mode. Set the centre to (r=1, c=1).
- FETCH at the first column of a row (c=1): issue 9 reads in column-major order over columns c-1, c, c+1, top to bottom within each column.
- FETCH for c>1: shift the window left one column, then issue 3 reads for column c+1, top, middle, bottom.
- Address = row*IMG_W + col. Each read returns on gray_data one cycle after the gray_req cycle.
- FETCH -> CAL after the last data capture.
- CAL: compute the code. ref = centre + thr, evaluated in PIX_W+1 bits with no wrap. Bit s_i = (n_i >= ref).
- Bit order: bit0 top-left, bit1 top, bit2 top-right, bit3 left, bit4 right, bit5 bottom-left, bit6 bottom, bit7 bottom-right.
- CAL -> WR. WR drives lbp_valid=1, lbp_addr = r*IMG_W+c and lbp_data = code, then advances the centre.
- Centre advance: c+1 if c < IMG_W-2; otherwise c=1 and r+1.
- WR -> FETCH while interior pixels remain.
- After the last interior pixel (r=IMG_H-2, c=IMG_W-2): WR -> BORDER if border_mode=1, else WR -> DONE.
- BORDER: one write per cycle with lbp_data=0, in ascending address order, covering row 0, columns 0 and IMG_W-1 of rows 1..IMG_H-2, and row IMG_H-1.
- BORDER performs 2*IMG_W + 2*(IMG_H-2) writes in total, then moves to DONE.
- DONE: finish=1. DONE -> IDLE when gray_ready=0, which clears finish. A new frame requires gray_ready to drop and rise again.
- Changes to thr or border_mode during a frame have no effect until the next frame start.

## Timing
- Reset values: gray_addr=0, gray_req=0, lbp_addr=0, lbp_data=0, lbp_valid=0, finish=0, state IDLE.
- A reset asserted mid-frame aborts the frame in the next cycle. No partial write follows.
- Row-start pixel: 9 request cycles + 1 capture + CAL + WR = 12 cycles.
- Subsequent pixels: 3 + 1 + 1 + 1 = 6 cycles, so lbp_valid pulses are 6 cycles apart within a row.
- gray_req is high only on issue cycles. gray_addr is held at 0 when gray_req=0.
- lbp_valid is never high in the same cycle as gray_req.
- lbp_data and lbp_addr hold their last value when lbp_valid=0.
- finish rises in the cycle after the final lbp_valid.

## Structure
- Package lbp_pkg: state enum, neighbour bit-index constants, border-mode encoding.
- Sub-module lbp_code: combinational comparator/encoder. Inputs are nine PIX_W pixels and thr; output is the 8-bit code. Instantiated once.
- Top module contains the FSM, row/column counters, the 3x3 window registers and the border sequencer.

## Test plan
- IMG_W=IMG_H=4, all pixels 50, thr=0, border_mode=0 -> 4 writes to addresses 5, 6, 9, 10 with data 0xFF. finish rises 1 cycle after the 4th write.
- Same size, pixel = its address, thr=0 -> data 0xF0 at all four interior addresses. Writes 5->6 and 9->10 are 6 cycles apart.
- Ramp image, thr=5 -> data 0x80 at addresses 5, 6, 9 and 10.
- Centre 250, all neighbours 255, thr=10 -> code 0x00. ref=260 must not wrap to 4.
- border_mode=1 on 4x4 -> 4 interior writes, then 12 consecutive writes of 0 to addresses 0, 1, 2, 3, 4, 7, 8, 11, 12, 13, 14, 15, then finish.
- Reset asserted during the second FETCH -> all outputs 0 the next cycle. Re-raising gray_ready reproduces the first scenario exactly.
